// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core: reset instruction,
// base opcodes decoded by controlUnit and the fetch FSM encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, ready/data back.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_logic.sv
// Next-PC selection (jump, taken branch, sequential) and alignment check.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_target,
    input  logic        i_branch,
    input  logic        i_branch_taken,
    input  logic        i_jal_en,
    output logic [31:0] o_pc_next,
    output logic        o_misalign
);

    // Jumps clear bit 0 of the target (JALR semantics); addition wraps mod 2^32.
    always_comb begin
        o_pc_next = i_pc + 32'd4;
        if (i_jal_en) begin
            o_pc_next = {i_target[31:1], 1'b0};
        end else if (i_branch && i_branch_taken) begin
            o_pc_next = i_target;
        end
        o_misalign = !is_word_aligned(o_pc_next);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one word per fetchEN from instruction
// memory and holds it in the instruction register for controlUnit.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetchEN,
    input  logic                      pcEN,
    input  logic                      branch,
    input  logic                      branch_taken,
    input  logic                      JalEN,
    input  logic [31:0]               target,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    output logic [31:0]               pc_plus4,
    output logic                      instr_valid,
    output logic                      fetch_busy,
    output logic                      misalign
);
    import riscv_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_pc_plus4;
    logic        r_misalign;

    logic [31:0] w_pc_next;
    logic [31:0] w_pc_eff;
    logic        w_pc_misalign;
    logic        w_pc_load;
    logic        w_misalign_set;
    logic        w_fetch_start;
    logic        w_capture;

    pc_next_logic u_pc_next (
        .i_pc           (r_pc),
        .i_target       (target),
        .i_branch       (branch),
        .i_branch_taken (branch_taken),
        .i_jal_en       (JalEN),
        .o_pc_next      (w_pc_next),
        .o_misalign     (w_pc_misalign)
    );

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus PC/fetch strobes; PC and fetch requests only act in IDLE.
    // A misaligned next-PC in the same cycle as fetchEN also blocks that fetch.
    always_comb begin
        w_state_next   = r_state;
        w_pc_load      = 1'b0;
        w_misalign_set = 1'b0;
        w_fetch_start  = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (pcEN) begin
                    if (w_pc_misalign) begin
                        w_misalign_set = 1'b1;
                    end else begin
                        w_pc_load = 1'b1;
                    end
                end
                if (fetchEN && !r_misalign && !w_misalign_set) begin
                    w_fetch_start = 1'b1;
                    w_state_next  = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem.imem_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = FETCH_DONE;
                end
            end
            FETCH_DONE: begin
                w_state_next = FETCH_IDLE;
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    // A fetch issued together with pcEN uses the freshly selected PC.
    assign w_pc_eff = w_pc_load ? w_pc_next : r_pc;

    // PC, request address, instruction register and sticky misalign flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_misalign <= 1'b0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
            if (w_misalign_set) begin
                r_misalign <= 1'b1;
            end
            if (w_fetch_start) begin
                r_addr <= w_pc_eff;
            end
            if (w_capture) begin
                r_instr    <= imem.imem_rdata;
                r_instr_pc <= r_addr;
                r_pc_plus4 <= r_addr + 32'd4;
            end
        end
    end

    assign imem.imem_req  = (r_state == FETCH_REQ);
    assign imem.imem_addr = r_addr;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign pc_plus4       = r_pc_plus4;
    assign instr_valid    = (r_state == FETCH_DONE);
    assign fetch_busy     = (r_state != FETCH_IDLE);
    assign misalign       = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected fetches.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchEN;
    logic        pcEN;
    logic        branch;
    logic        branch_taken;
    logic        JalEN;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_busy;
    logic        misalign;

    always #5 clk = ~clk;

    instr_fetch_unit_if u_imem ();

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetchEN      (fetchEN),
        .pcEN         (pcEN),
        .branch       (branch),
        .branch_taken (branch_taken),
        .JalEN        (JalEN),
        .target       (target),
        .imem         (u_imem),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .fetch_busy   (fetch_busy),
        .misalign     (misalign)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every instr_valid pulse must match the oldest outstanding fetch.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            n_valid++;
            chk("sb_occupancy", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("instr", instr, mon_e.instr);
                chk("instr_pc", instr_pc, mon_e.pc);
                chk("pc_plus4", pc_plus4, mon_e.pc4);
            end
        end
    end

    // Caller sets pcEN/branch/JalEN/target for the fetchEN cycle beforehand.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input int waits, input bit noise, input string tag);
        fetchEN = 1'b1;
        sb_q.push_back('{instr: data, pc: exp_addr, pc4: exp_addr + 32'd4});
        tick();
        fetchEN = 1'b0; pcEN = 1'b0; branch = 1'b0; branch_taken = 1'b0; JalEN = 1'b0;
        chk({tag, "_req"}, 32'(u_imem.imem_req), 32'd1);
        chk({tag, "_addr"}, u_imem.imem_addr, exp_addr);
        chk({tag, "_busy"}, 32'(fetch_busy), 32'd1);
        for (int i = 0; i < waits; i++) begin
            if (noise) begin
                fetchEN = 1'b1;
                pcEN    = 1'b1;
            end
            tick();
            chk({tag, "_wait_req"}, 32'(u_imem.imem_req), 32'd1);
            chk({tag, "_wait_addr"}, u_imem.imem_addr, exp_addr);
            chk({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
        end
        u_imem.imem_ready = 1'b1;
        u_imem.imem_rdata = data;
        tick();
        u_imem.imem_ready = 1'b0;
        u_imem.imem_rdata = 32'hDEAD_BEEF;
        fetchEN = 1'b0;
        pcEN    = 1'b0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_req_drop"}, 32'(u_imem.imem_req), 32'd0);
        tick();
        chk({tag, "_valid_end"}, 32'(instr_valid), 32'd0);
        chk({tag, "_idle_req"}, 32'(u_imem.imem_req), 32'd0);
        chk({tag, "_idle_busy"}, 32'(fetch_busy), 32'd0);
        chk({tag, "_hold_instr"}, instr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fetchEN = 1'b0; pcEN = 1'b0; branch = 1'b0;
        branch_taken = 1'b0; JalEN = 1'b0; target = 32'h0;
        u_imem.imem_ready = 1'b0;
        u_imem.imem_rdata = 32'h0;
        tick();
        tick();

        chk("rst_req", 32'(u_imem.imem_req), 32'd0);
        chk("rst_addr", u_imem.imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b1;
        tick();

        // zero-wait fetch at reset PC
        do_fetch(32'h0000_0000, 32'h0050_0093, 0, 1'b0, "t1");

        // sequential pcEN, then a fetch with three wait states
        pcEN = 1'b1;
        tick();
        pcEN = 1'b0;
        do_fetch(32'h0000_0004, 32'h00A0_0113, 3, 1'b0, "t2");

        // taken branch with pcEN and fetchEN together
        branch = 1'b1; branch_taken = 1'b1; target = 32'h0000_0100; pcEN = 1'b1;
        do_fetch(32'h0000_0100, 32'h0010_8093, 0, 1'b0, "t3a");

        // not-taken branch falls through to pc+4
        branch = 1'b1; branch_taken = 1'b0; target = 32'h0000_0200; pcEN = 1'b1;
        do_fetch(32'h0000_0104, 32'hFE00_0EE3, 1, 1'b0, "t3b");

        // misaligned jump target is rejected and blocks further fetches
        JalEN = 1'b1; target = 32'h0000_0203; pcEN = 1'b1;
        tick();
        JalEN = 1'b0; pcEN = 1'b0;
        chk("t4_misalign", 32'(misalign), 32'd1);
        chk("t4_no_req", 32'(u_imem.imem_req), 32'd0);
        fetchEN = 1'b1;
        tick();
        fetchEN = 1'b0;
        chk("t4_blocked_req", 32'(u_imem.imem_req), 32'd0);
        chk("t4_blocked_busy", 32'(fetch_busy), 32'd0);
        chk("t4_sticky", 32'(misalign), 32'd1);
        tick();
        chk("t4_blocked_valid", 32'(instr_valid), 32'd0);

        rst = 1'b0;
        tick();
        chk("t4_rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b1;
        tick();

        // jump clears bit 0 of the target; pc_plus4 wraps to zero
        JalEN = 1'b1; target = 32'hFFFF_FFFD; pcEN = 1'b1;
        do_fetch(32'hFFFF_FFFC, 32'h0000_0073, 0, 1'b0, "t5a");

        // pc+4 wraps; fetchEN and pcEN held during REQ are ignored
        pcEN = 1'b1;
        do_fetch(32'h0000_0000, 32'h1234_5037, 2, 1'b1, "t5b");
        do_fetch(32'h0000_0000, 32'h0000_0517, 0, 1'b0, "t5c");

        // reset while a request is waiting on memory
        fetchEN = 1'b1;
        tick();
        fetchEN = 1'b0;
        chk("t6_req", 32'(u_imem.imem_req), 32'd1);
        tick();
        chk("t6_wait_req", 32'(u_imem.imem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_req", 32'(u_imem.imem_req), 32'd0);
        chk("t6_rst_instr", instr, 32'h0000_0013);
        chk("t6_rst_busy", 32'(fetch_busy), 32'd0);
        chk("t6_rst_pc_plus4", pc_plus4, 32'h4);
        tick();
        rst = 1'b1;
        u_imem.imem_ready = 1'b1;
        u_imem.imem_rdata = 32'h5555_5555;
        tick();
        u_imem.imem_ready = 1'b0;
        chk("t6_no_valid", 32'(instr_valid), 32'd0);
        chk("t6_instr_kept", instr, 32'h0000_0013);
        tick();
        chk("t6_no_valid_late", 32'(instr_valid), 32'd0);

        chk("valid_count", 32'(n_valid), 32'd7);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
